// File: rtl/demux_sel_sequencer_pkg.sv
// demux_sel_sequencer_pkg: shared widths, channel-count helper and FSM encodings for the demux select sequencer
package demux_sel_sequencer_pkg;
    localparam int SEL_W_DEF = 2;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN = 1'b1;
    function automatic int num_ch(input int sel_w);
        return 1 << sel_w;
    endfunction
endpackage

// File: rtl/demux_sel_sequencer_next_chan_pick.sv
// next_chan_pick: next enabled channel strictly above cur, wrapping to the lowest enabled one
module next_chan_pick
    import demux_sel_sequencer_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [SEL_W-1:0]         cur,
    input  logic [num_ch(SEL_W)-1:0] mask,
    output logic [SEL_W-1:0]         nxt,
    output logic                     wrapped,
    output logic                     any
);
    localparam int NUM_CH = num_ch(SEL_W);
    logic [SEL_W-1:0] hi_idx, lo_idx;
    logic hi_found;
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_found = 1'b0;
        // scanning downward leaves the lowest qualifying index in each slot
        for (int n = NUM_CH - 1; n >= 0; n--) begin
            if (mask[n]) begin
                lo_idx = SEL_W'(n);
                if (n > int'(cur)) begin
                    hi_idx = SEL_W'(n);
                    hi_found = 1'b1;
                end
            end
        end
        nxt = hi_found ? hi_idx : lo_idx;
        wrapped = !hi_found;
        any = |mask;
    end
endmodule

// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer: round-robin select/data driver for the 1-to-4 demux with per-channel dwell.
// Define DEMUX_SEQ_ONESHOT_EN to stop after a single sweep instead of repeating.
module demux_sel_sequencer
    import demux_sel_sequencer_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [DWELL_W-1:0]       dwell,
    input  logic [num_ch(SEL_W)-1:0] ch_mask,
    input  logic                     i_in,
    output logic [SEL_W-1:0]         s,
    output logic                     i,
    output logic                     busy,
    output logic                     wrap
);
`ifdef DEMUX_SEQ_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif
    logic [0:0] state;
    logic [DWELL_W-1:0] cnt, reload;
    logic [SEL_W-1:0] pick_s;
    logic pick_wrapped, pick_any;
    assign reload = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign busy = (state == ST_RUN);
    // in IDLE, searching above the top index yields the lowest enabled channel
    next_chan_pick #(.SEL_W(SEL_W)) u_pick (
        .cur(busy ? s : '1),
        .mask(ch_mask),
        .nxt(pick_s),
        .wrapped(pick_wrapped),
        .any(pick_any)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            s <= '0;
            i <= 1'b0;
            wrap <= 1'b0;
            cnt <= '0;
        end else if (state == ST_IDLE) begin
            wrap <= 1'b0;
            i <= 1'b0;
            if (start && pick_any) begin
                state <= ST_RUN;
                s <= pick_s;
                cnt <= reload;
            end
        end else if (stop || (cnt == '0 && !pick_any)) begin
            state <= ST_IDLE;
            s <= '0;
            i <= 1'b0;
            wrap <= 1'b0;
        end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
            i <= i_in;
            wrap <= 1'b0;
        end else begin
            wrap <= pick_wrapped;
            cnt <= reload;
            if (ONESHOT && pick_wrapped) begin
                state <= ST_IDLE;
                s <= '0;
                i <= 1'b0;
            end else begin
                s <= pick_s;
                i <= i_in;
            end
        end
    end
endmodule

// File: tb/tb_demux_sel_sequencer.sv
// tb_demux_sel_sequencer: directed stimulus, rule-level reference model and literal sequence checks
module tb_demux_sel_sequencer;
    logic clk = 1'b0;
    logic rst, start, stop, i_in;
    logic [7:0] dwell;
    logic [3:0] ch_mask;
    logic [1:0] dut_s;
    logic dut_i, dut_busy, dut_wrap;
    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;
    int m_s, m_i, m_wrap, m_left;
    bit m_run;
    int es[$];
    int ew[$];

    demux_sel_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dwell(dwell),
        .ch_mask(ch_mask), .i_in(i_in), .s(dut_s), .i(dut_i), .busy(dut_busy), .wrap(dut_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int hold_len(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int lowest_en(input int m);
        for (int c = 0; c < 4; c++) if (m[c]) return c;
        return -1;
    endfunction

    function automatic int next_en(input int m, input int c);
        for (int k = 1; k <= 4; k++) if (m[(c + k) % 4]) return (c + k) % 4;
        return -1;
    endfunction

    // reference model: a channel is occupied for hold_len(dwell) cycles, then moves on
    always @(posedge clk) begin
        int nx;
        if (rst) begin
            armed = 1'b1;
            m_run = 1'b0; m_s = 0; m_i = 0; m_wrap = 0; m_left = 0;
        end else if (!m_run) begin
            m_wrap = 0; m_i = 0; m_s = 0;
            if (start && ch_mask != 0) begin
                m_run = 1'b1;
                m_s = lowest_en(int'(ch_mask));
                m_left = hold_len(int'(dwell));
            end
        end else if (stop) begin
            m_run = 1'b0; m_s = 0; m_i = 0; m_wrap = 0;
        end else begin
            m_i = int'(i_in);
            m_wrap = 0;
            if (m_left > 1) m_left--;
            else if (ch_mask == 0) begin
                m_run = 1'b0; m_s = 0; m_i = 0;
            end else begin
                nx = next_en(int'(ch_mask), m_s);
                m_wrap = (nx <= m_s) ? 1 : 0;
                m_s = nx;
                m_left = hold_len(int'(dwell));
`ifdef DEMUX_SEQ_ONESHOT_EN
                if (m_wrap == 1) begin
                    m_run = 1'b0; m_s = 0; m_i = 0;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model_s", int'(dut_s), m_s);
            chk("model_i", int'(dut_i), m_i);
            chk("model_busy", int'(dut_busy), int'(m_run));
            chk("model_wrap", int'(dut_wrap), m_wrap);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        i_in = 1'($urandom_range(0, 1));
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic seq(input string tag);
        for (int k = 0; k < es.size(); k++) begin
            chk({tag, "_s"}, int'(dut_s), es[k]);
            chk({tag, "_wrap"}, int'(dut_wrap), ew[k]);
            chk({tag, "_busy"}, int'(dut_busy), 1);
            if (k < es.size() - 1) tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dwell = 8'd2; ch_mask = 4'b1111; i_in = 1'b0;
        tick(); tick();
        chk("reset_s", int'(dut_s), 0);
        chk("reset_i", int'(dut_i), 0);
        chk("reset_busy", int'(dut_busy), 0);
        chk("reset_wrap", int'(dut_wrap), 0);
        rst = 1'b0;
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        chk("idle_stop_busy", int'(dut_busy), 0);
`ifndef DEMUX_SEQ_ONESHOT_EN
        go();
        es = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        ew = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        seq("full");
        start = 1'b1;
        tick(); tick(); tick(); tick();
        start = 1'b0;
        chk("run_start_ignored_s", int'(dut_s), 2);
        halt();
        chk("stop_s", int'(dut_s), 0);
        chk("stop_i", int'(dut_i), 0);
        chk("stop_busy", int'(dut_busy), 0);
        dwell = 8'd1; ch_mask = 4'b1010;
        go();
        es = '{1, 3, 1, 3, 1};
        ew = '{0, 0, 1, 0, 1};
        seq("sparse");
        halt();
        dwell = 8'd0; ch_mask = 4'b1111;
        go();
        dwell = 8'd3;
        es = '{0, 1, 1, 1, 2};
        ew = '{0, 0, 0, 0, 0};
        seq("dwell");
        halt();
        dwell = 8'd1; ch_mask = 4'b0100;
        go();
        es = '{2, 2, 2};
        ew = '{0, 1, 1};
        seq("single");
        halt();
`else
        dwell = 8'd1; ch_mask = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            go();
            es = '{0, 1, 2, 3};
            ew = '{0, 0, 0, 0};
            seq("oneshot");
            tick();
            chk("oneshot_end_s", int'(dut_s), 0);
            chk("oneshot_end_wrap", int'(dut_wrap), 1);
            chk("oneshot_end_busy", int'(dut_busy), 0);
            tick();
            chk("oneshot_wrap_once", int'(dut_wrap), 0);
        end
`endif
        dwell = 8'd1; ch_mask = 4'b1111;
        go(); tick();
        chk("pre_rst_s", int'(dut_s), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_s", int'(dut_s), 0);
        chk("mid_rst_busy", int'(dut_busy), 0);
        chk("mid_rst_i", int'(dut_i), 0);
        ch_mask = 4'b1100;
        go();
        chk("restart_s", int'(dut_s), 2);
        halt();
        ch_mask = 4'b0000;
        go();
        chk("empty_start_busy", int'(dut_busy), 0);
        dwell = 8'd3; ch_mask = 4'b1111;
        go();
        ch_mask = 4'b0000;
        tick();
        chk("clear_hold1_busy", int'(dut_busy), 1);
        tick();
        chk("clear_hold2_busy", int'(dut_busy), 1);
        tick();
        chk("clear_adv_busy", int'(dut_busy), 0);
        chk("clear_adv_s", int'(dut_s), 0);
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
